// File: rtl/multi_blinker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_blinker: per-channel toggle / pulse / PWM blinker with shadow cfg   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module multi_blinker #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int DEFAULT_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_duty,
  input  logic [1:0]          cfg_mode,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] light,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [1:0]       c_MODE_OFF = 2'd0;
  localparam logic [1:0]       c_MODE_TOG = 2'd1;
  localparam logic [1:0]       c_MODE_PUL = 2'd2;
  localparam logic [1:0]       c_MODE_PWM = 2'd3;
  localparam logic [WIDTH-1:0] c_DEF_P    = WIDTH'(DEFAULT_PERIOD);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_act_p, r_act_d, r_sh_p, r_sh_d;
    logic [1:0]       r_act_m, r_sh_m;
    logic             r_pend, r_light, r_tick;

    logic             w_sel, w_wrap, w_apply, w_light_nxt;
    logic [WIDTH-1:0] w_new_p, w_new_d;
    logic [1:0]       w_new_m;

    assign w_sel   = cfg_we && (cfg_ch == 4'(gi));
    assign w_wrap  = (r_cnt == r_act_p);
    assign w_apply = !en[gi] || w_wrap;

    // A write landing on the apply edge bypasses the shadow entirely.
    assign w_new_p = w_sel ? cfg_period : r_sh_p;
    assign w_new_d = w_sel ? cfg_duty   : r_sh_d;
    assign w_new_m = w_sel ? cfg_mode   : r_sh_m;

    always_comb begin
      w_light_nxt = 1'b0;
      unique case (r_act_m)
        c_MODE_TOG: w_light_nxt = r_light ^ w_wrap;
        c_MODE_PUL: w_light_nxt = w_wrap;
        c_MODE_PWM: w_light_nxt = (r_cnt < r_act_d);
        default:    w_light_nxt = 1'b0;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_act_p <= c_DEF_P;
        r_act_d <= '0;
        r_act_m <= c_MODE_TOG;
        r_sh_p  <= c_DEF_P;
        r_sh_d  <= '0;
        r_sh_m  <= c_MODE_TOG;
        r_pend  <= 1'b0;
        r_light <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        if (w_apply) begin
          r_act_p <= w_new_p;
          r_act_d <= w_new_d;
          r_act_m <= w_new_m;
          r_sh_p  <= w_new_p;
          r_sh_d  <= w_new_d;
          r_sh_m  <= w_new_m;
          r_pend  <= 1'b0;
        end else if (w_sel) begin
          r_sh_p  <= cfg_period;
          r_sh_d  <= cfg_duty;
          r_sh_m  <= cfg_mode;
          r_pend  <= 1'b1;
        end

        if (!en[gi]) begin
          r_cnt   <= '0;
          r_light <= 1'b0;
          r_tick  <= 1'b0;
        end else begin
          r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
          r_tick  <= w_wrap && (r_act_m != c_MODE_OFF);
          // A mode switch starts the new waveform from a clean low level.
          r_light <= (w_wrap && (w_new_m != r_act_m)) ? 1'b0 : w_light_nxt;
        end
      end
    end

    assign light[gi]   = r_light;
    assign tick[gi]    = r_tick;
    assign pending[gi] = r_pend;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_blinker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multi_blinker: directed vector bench for multi_blinker                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_multi_blinker;
  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_ch = '0;
  logic [W-1:0]  cfg_period = '0;
  logic [W-1:0]  cfg_duty = '0;
  logic [1:0]    cfg_mode = '0;
  logic [CH-1:0] en = '0;
  logic [CH-1:0] light, tick, pending;

  int n_tests = 0;
  int n_fail  = 0;

  multi_blinker #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_PERIOD(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_mode(cfg_mode),
    .en(en), .light(light), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [3:0] ch;
    logic [7:0] p;
    logic [7:0] d;
    logic [1:0] m;
    logic [3:0] en;
    logic [3:0] light;
    logic [3:0] tick;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic we, input logic [3:0] ch, input logic [7:0] p,
                              input logic [7:0] d, input logic [1:0] m, input logic [3:0] e,
                              input logic [3:0] l, input logic [3:0] t, input logic [3:0] pd);
    vec_t v;
    v.we = we; v.ch = ch; v.p = p; v.d = d; v.m = m; v.en = e;
    v.light = l; v.tick = t; v.pend = pd;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] ch, input logic [7:0] p,
                       input logic [7:0] d, input logic [1:0] m, input logic [3:0] e);
    cfg_we = we; cfg_ch = ch; cfg_period = p; cfg_duty = d; cfg_mode = m; en = e;
  endtask

  task automatic check(input string nm, input logic [3:0] el, input logic [3:0] et,
                       input logic [3:0] ep);
    n_tests++;
    if (light !== el || tick !== et || pending !== ep) begin
      n_fail++;
      $display("FAIL %s: light/tick/pending got %b/%b/%b expected %b/%b/%b",
               nm, light, tick, pending, el, et, ep);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 4'b0000);
    cyc();
    cyc();
    check("reset_state", 4'b0, 4'b0, 4'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch1 pulse P=3, then P=0; ch2 PWM P=9 D=3
    tbl[0]  = mk(1, 1, 3, 0, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[3]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[4]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    tbl[5]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[6]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[7]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[8]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    tbl[9]  = mk(1, 1, 0, 0, 2, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    tbl[10] = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    tbl[11] = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    tbl[12] = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    tbl[13] = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    tbl[14] = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    tbl[15] = mk(1, 2, 9, 3, 3, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
    tbl[16] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0110, 4'b0010, 4'b0000);
    tbl[17] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0110, 4'b0010, 4'b0000);
    tbl[18] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0110, 4'b0010, 4'b0000);
    tbl[19] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0010, 4'b0010, 4'b0000);
    tbl[20] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0010, 4'b0010, 4'b0000);
    tbl[21] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0010, 4'b0010, 4'b0000);
    tbl[22] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0010, 4'b0010, 4'b0000);
    tbl[23] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0010, 4'b0010, 4'b0000);
    tbl[24] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0010, 4'b0010, 4'b0000);
    tbl[25] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0010, 4'b0110, 4'b0000);
    tbl[26] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0110, 4'b0010, 4'b0000);
    tbl[27] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0110, 4'b0010, 4'b0000);

    // Default config: toggle, P=8
    do_reset();
    drive(0, 0, 0, 0, 0, 4'b0001);
    for (int k = 1; k <= 27; k++) begin
      cyc();
      check($sformatf("default_k%0d", k), {3'b0, ((k / 9) % 2) == 1},
            {3'b0, (k % 9) == 0}, 4'b0);
    end

    // Table vectors
    do_reset();
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].we, tbl[i].ch, tbl[i].p, tbl[i].d, tbl[i].m, tbl[i].en);
      cyc();
      check($sformatf("vec%0d", i), tbl[i].light, tbl[i].tick, tbl[i].pend);
    end

    // PWM D=0 constant low, D=12 constant high
    do_reset();
    drive(1, 2, 9, 0, 3, 4'b0000);
    cyc();
    check("pwm_d0_wr", 4'b0, 4'b0, 4'b0);
    drive(0, 0, 0, 0, 0, 4'b0100);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("pwm_d0_k%0d", k), 4'b0, (k == 10) ? 4'b0100 : 4'b0, 4'b0);
    end
    drive(1, 2, 9, 12, 3, 4'b0000);
    cyc();
    check("pwm_d12_wr", 4'b0, 4'b0, 4'b0);
    drive(0, 0, 0, 0, 0, 4'b0100);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("pwm_d12_k%0d", k), 4'b0100, (k == 10) ? 4'b0100 : 4'b0, 4'b0);
    end

    // Shadow update: write P=2 at c=3, old period completes
    do_reset();
    drive(0, 0, 0, 0, 0, 4'b0001);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("shadow_pre_k%0d", k), 4'b0, 4'b0, 4'b0);
    end
    drive(1, 0, 2, 0, 1, 4'b0001);
    cyc();
    check("shadow_wr", 4'b0, 4'b0, 4'b0001);
    drive(0, 0, 0, 0, 0, 4'b0001);
    for (int k = 5; k <= 8; k++) begin
      cyc();
      check($sformatf("shadow_hold_k%0d", k), 4'b0, 4'b0, 4'b0001);
    end
    for (int k = 9; k <= 18; k++) begin
      cyc();
      check($sformatf("shadow_new_k%0d", k), {3'b0, (((k - 9) / 3) % 2) == 0},
            {3'b0, ((k - 9) % 3) == 0}, 4'b0);
    end

    // Write coinciding with the wrap edge
    do_reset();
    drive(0, 0, 0, 0, 0, 4'b0001);
    for (int k = 1; k <= 8; k++) cyc();
    check("coinc_pre", 4'b0, 4'b0, 4'b0);
    drive(1, 0, 1, 0, 1, 4'b0001);
    cyc();
    check("coinc_wrap", 4'b0001, 4'b0001, 4'b0);
    drive(0, 0, 0, 0, 0, 4'b0001);
    for (int k = 10; k <= 15; k++) begin
      cyc();
      check($sformatf("coinc_k%0d", k), {3'b0, (((k - 9) / 2) % 2) == 0},
            {3'b0, ((k - 9) % 2) == 0}, 4'b0);
    end

    // Disable mid-period, write PWM, ignored out-of-range write, re-enable
    do_reset();
    drive(0, 0, 0, 0, 0, 4'b0001);
    for (int k = 1; k <= 14; k++) cyc();
    check("dis_pre", 4'b0001, 4'b0, 4'b0);
    drive(0, 0, 0, 0, 0, 4'b0000);
    cyc();
    check("dis_off", 4'b0, 4'b0, 4'b0);
    drive(1, 0, 4, 2, 3, 4'b0000);
    cyc();
    check("dis_wr", 4'b0, 4'b0, 4'b0);
    drive(1, 4, 0, 0, 2, 4'b0000);
    cyc();
    check("dis_bad_ch", 4'b0, 4'b0, 4'b0);
    drive(0, 0, 0, 0, 0, 4'b0001);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check($sformatf("reen_k%0d", k), {3'b0, ((k - 1) % 5) < 2},
            {3'b0, (k % 5) == 0}, 4'b0);
    end

    // Asynchronous reset mid-period
    do_reset();
    drive(0, 0, 0, 0, 0, 4'b1111);
    for (int k = 1; k <= 9; k++) cyc();
    check("all_k9", 4'b1111, 4'b1111, 4'b0);
    cyc();
    cyc();
    drive(1, 3, 5, 0, 1, 4'b1111);
    cyc();
    check("all_pend", 4'b1111, 4'b0, 4'b1000);
    drive(0, 0, 0, 0, 0, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 4'b0, 4'b0, 4'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
